ps2_kbd_encoder: RTL and testbench
==================================

PS2_KBD_ENCODER -- requirements
Module: ps2_kbd_encoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, meaning: receive FIFO entries; power of two, minimum 2.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ps2_clk  input  1  raw PS/2 clock from the device; asynchronous to clk.
REQ-005 ps2_data  input  1  raw PS/2 data; sampled on falling edges of ps2_clk.
REQ-006 nextdata_n  input  1  active-low pop strobe for the receive FIFO.
REQ-007 data  output  8  head-of-FIFO byte.
REQ-008 ready  output  1  FIFO not empty.
REQ-009 overflow  output  1  sticky flag; a byte was lost because the FIFO was full.
REQ-010 enc_in  input  8  priority encoder input.
REQ-011 enc_en  input  1  priority encoder enable.
REQ-012 enc_out  output  3  index of the highest set bit of enc_in.
REQ-013 enc_valid  output  1  enc_in is non-zero while enabled.
REQ-014 dec_in  input  3  decoder input.
REQ-015 dec_en  input  1  decoder enable.
REQ-016 dec_out  output  8  one-hot decoder output.

Function
REQ-017 Synchronisation: 3-flop synchroniser on ps2_clk; falling edge detected when the two oldest samples are 1 followed by 0.
REQ-018 Data capture: on each detected falling edge, ps2_data is sampled directly, without a synchroniser, into a 10-bit shift buffer; a 4-bit counter advances 0..10.
REQ-019 Frame layout: bit0 start (0), bits1-8 data LSB-first, bit9 parity, bit10 stop (1).
REQ-020 Frame completion: on the 11th edge (counter==10), the frame is valid iff start==0, stop==1 and the parity check passes (see REQ-032).
  - Valid frame: byte pushed.
  - Any frame: counter returns to 0.
  - Invalid frame: silently discarded.
REQ-021 Push timing: the byte is visible on data/ready on the clk edge after the edge-detect cycle.
REQ-022 FIFO type: show-ahead; data = mem[r_ptr] combinationally; ready = (w_ptr != r_ptr) in a pointer scheme with an extra wrap bit.
REQ-023 Pop: in every clk cycle where nextdata_n==0 and ready==1, r_ptr increments by one; pop while empty is ignored.
REQ-024 Push to full FIFO without a same-cycle pop: byte dropped, overflow set to 1; overflow stays set until reset.
REQ-025 Push and pop in the same cycle: both performed; a full FIFO accepts the push and overflow is not set.
REQ-026 Pointer wrap-around: pointers wrap modulo FIFO_DEPTH; data order is preserved across wrap.
REQ-027 Priority encoder (combinational):
  - enc_en==0: enc_out=0, enc_valid=0.
  - enc_en==1, enc_in==0: enc_out=0, enc_valid=0.
  - Otherwise: enc_out = index of the highest 1 bit, enc_valid=1.
REQ-028 Decoder (combinational): dec_en==0 gives dec_out=0; otherwise dec_out = 1 << dec_in.

Reset
REQ-029 While rst==1, independent of clk:
  - synchroniser flops = 1.
  - bit counter = 0.
  - w_ptr = r_ptr = 0.
  - overflow = 0.
  - FIFO memory = 0.
  - Hence ready=0 and data=8'h00.
REQ-030 Reset mid-frame discards the partial frame; reception restarts at the next start bit after release.
REQ-031 Encoder and decoder are unaffected by rst.

Configuration
REQ-032 Macro PS2_PARITY_CHECK_EN:
  - Defined: a frame additionally requires odd parity over data bits plus the parity bit; failing frames are discarded.
  - Undefined: the parity bit is ignored.

Verification
REQ-033 Send frame for 0x1C with parity 0, stop 1 -> ready=1 and data=0x1C within 5 clk cycles of the final ps2_clk fall; pulse nextdata_n low for 1 cycle -> ready=0.
REQ-034 Send 9 valid bytes 0x01..0x09 with no pops (FIFO_DEPTH=8) -> overflow=1; pops return 0x01..0x08 in order, then ready=0.
REQ-035 With PS2_PARITY_CHECK_EN defined, send 0x1C with parity 1 -> ready stays 0; send a frame with stop bit 0 -> discarded in both configurations.
REQ-036 Assert rst after 5 bits of a frame, release, send 0x2A -> data=0x2A, ready=1, overflow=0.
REQ-037 Encoder/decoder:
  - enc_en=1, enc_in=8'b0010_0110 -> enc_out=5, enc_valid=1.
  - enc_in=0 -> enc_out=0, enc_valid=0.
  - dec_en=1, dec_in=3 -> dec_out=8'h08.
  - dec_en=0 -> dec_out=8'h00.

Source files
------------

// File: rtl/ps2_kbd_encoder.sv
// PS/2 keyboard receiver with show-ahead byte FIFO, plus an 8:3 priority encoder and a 3:8 decoder.
// Define PS2_PARITY_CHECK_EN to reject frames that fail odd parity.
module ps2_kbd_encoder #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       nextdata_n,
   output logic [7:0] data,
   output logic       ready,
   output logic       overflow,
   input  logic [7:0] enc_in,
   input  logic       enc_en,
   output logic [2:0] enc_out,
   output logic       enc_valid,
   input  logic [2:0] dec_in,
   input  logic       dec_en,
   output logic [7:0] dec_out
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [2:0]  sync;
   logic        fall;
   logic [9:0]  shift_buf;
   logic [3:0]  bit_cnt;
   logic        frame_ok;
   logic        push, pop, full;
   logic [AW:0] w_ptr, r_ptr;
   logic [7:0]  mem [FIFO_DEPTH];

   assign fall = sync[2] & ~sync[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= 3'b111;
      else     sync <= {sync[1:0], ps2_clk};
   end

   // ps2_data is stable for the whole low phase of ps2_clk, so no synchroniser is needed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_buf <= '0;
         bit_cnt   <= '0;
      end else if (fall) begin
         if (bit_cnt == 4'd10) begin
            bit_cnt <= '0;
         end else begin
            shift_buf <= {ps2_data, shift_buf[9:1]};
            bit_cnt   <= bit_cnt + 4'd1;
         end
      end
   end

   // At the 11th edge: shift_buf = {parity, data[7:0], start}, ps2_data = stop
   always_comb begin
      frame_ok = ~shift_buf[0] & ps2_data;
`ifdef PS2_PARITY_CHECK_EN
      frame_ok = frame_ok & (^shift_buf[9:1]);
`endif
   end

   assign push  = fall && (bit_cnt == 4'd10) && frame_ok;
   assign ready = (w_ptr != r_ptr);
   assign full  = (w_ptr[AW] != r_ptr[AW]) && (w_ptr[AW-1:0] == r_ptr[AW-1:0]);
   assign pop   = ~nextdata_n & ready;
   assign data  = mem[r_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_ptr    <= '0;
         r_ptr    <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (pop) r_ptr <= r_ptr + (AW+1)'(1);
         // a same-cycle pop frees the head slot, so a full FIFO still accepts the byte
         if (push && (!full || pop)) begin
            mem[w_ptr[AW-1:0]] <= shift_buf[8:1];
            w_ptr              <= w_ptr + (AW+1)'(1);
         end else if (push) begin
            overflow <= 1'b1;
         end
      end
   end

   always_comb begin
      enc_out   = '0;
      enc_valid = 1'b0;
      if (enc_en) begin
         for (int i = 0; i < 8; i++) begin
            if (enc_in[i]) begin
               enc_out   = 3'(i);
               enc_valid = 1'b1;
            end
         end
      end
   end

   assign dec_out = dec_en ? (8'h01 << dec_in) : 8'h00;

endmodule

// File: tb/tb_ps2_kbd_encoder.sv
// Scoreboard bench for ps2_kbd_encoder: frames go out on ps2_clk/ps2_data, expected bytes queue up, pops compare.
module tb_ps2_kbd_encoder;
   localparam int DEPTH = 8;

   logic       clk = 0, rst = 1;
   logic       ps2_clk = 1, ps2_data = 1, nextdata_n = 1;
   logic [7:0] data, enc_in = 0, dec_out;
   logic       ready, overflow, enc_en = 0, enc_valid, dec_en = 0;
   logic [2:0] enc_out, dec_in = 0;

   int         n_vec = 0, n_err = 0;
   logic [7:0] exp_q [$];
   logic       exp_ovf = 0;

   ps2_kbd_encoder #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .nextdata_n(nextdata_n), .data(data), .ready(ready), .overflow(overflow),
      .enc_in(enc_in), .enc_en(enc_en), .enc_out(enc_out), .enc_valid(enc_valid),
      .dec_in(dec_in), .dec_en(dec_en), .dec_out(dec_out));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, act, exp);
      end
   endtask

   // Sends the first nbits of a frame; a complete frame updates the scoreboard.
   task automatic send(input logic [7:0] b, input logic par, input logic stp, input int nbits);
      logic [10:0] f;
      logic        ok;
      f = {stp, par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk) ps2_data = f[i];
         repeat (5) @(negedge clk);
         ps2_clk = 0;
         repeat (5) @(negedge clk);
         ps2_clk = 1;
      end
      if (nbits == 11) begin
         ok = stp;
`ifdef PS2_PARITY_CHECK_EN
         ok = ok & (^{b, par});
`endif
         if (ok) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else exp_ovf = 1;
         end
      end
   endtask

   task automatic drain;
      int t;
      while (exp_q.size() > 0) begin
         t = 0;
         while (!ready && t < 20) begin @(negedge clk); t++; end
         chk("rdy_wait", ready, 1);
         chk("pop_data", data, exp_q.pop_front());
         nextdata_n = 0;
         @(negedge clk) nextdata_n = 1;
      end
      @(negedge clk);
      chk("empty", ready, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ready", ready, 0);
      chk("rst_data", data, 8'h00);
      chk("rst_ovf", overflow, 0);
      rst = 0;

      enc_en = 1; enc_in = 8'b0010_0110; #1;
      chk("enc_out_26", enc_out, 5); chk("enc_vld_26", enc_valid, 1);
      enc_in = 8'h80; #1; chk("enc_out_80", enc_out, 7);
      enc_in = 8'h01; #1; chk("enc_out_01", {enc_valid, enc_out}, 4'b1000);
      enc_in = 8'h00; #1;
      chk("enc_out_0", enc_out, 0); chk("enc_vld_0", enc_valid, 0);
      enc_en = 0; enc_in = 8'hFF; #1; chk("enc_dis", {enc_valid, enc_out}, 0);
      dec_en = 1; dec_in = 3; #1; chk("dec_3", dec_out, 8'h08);
      dec_in = 7; #1; chk("dec_7", dec_out, 8'h80);
      dec_in = 0; #1; chk("dec_0", dec_out, 8'h01);
      dec_en = 0; dec_in = 3; #1; chk("dec_dis", dec_out, 8'h00);

      // basic frame: checked 5 cycles after the final ps2_clk fall
      send(8'h1C, 0, 1, 11);
      chk("rdy_1c", ready, 1);
      drain();

      send(8'h55, 1, 0, 11);        // bad stop bit
      repeat (5) @(negedge clk);
      chk("bad_stop", ready, 0);

      send(8'h1C, 1, 1, 11);        // wrong parity: dropped only with checking enabled
      repeat (5) @(negedge clk);
      chk("par_rdy", ready, exp_q.size() != 0);
      drain();

      for (int i = 1; i <= 9; i++) send(8'(i), ~^8'(i), 1, 11);
      chk("ovf_set", overflow, exp_ovf);
      chk("ovf_exp", exp_ovf, 1);
      drain();
      chk("ovf_sticky", overflow, 1);

      // wrapped pointers keep order
      for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), ~^(8'hA0 + 8'(i)), 1, 11);
      drain();

      send(8'h77, 0, 1, 5);
      @(negedge clk) rst = 1;
      exp_q.delete(); exp_ovf = 0;
      @(negedge clk);
      chk("midrst_rdy", ready, 0);
      chk("midrst_ovf", overflow, 0);
      rst = 0;
      send(8'h2A, ~^8'h2A, 1, 11);
      chk("rdy_2a", ready, 1);
      chk("ovf_2a", overflow, 0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL timeout: got running, want finished");
      $fatal(1);
   end
endmodule
